// File: rtl/ve_pkg.sv
// Shared constants, types and the column-ordered partial-product schedule
// for the sequential 32x32 Vedic multiplier.
package ve_pkg;

  localparam int unsigned CW    = 8;
  localparam int unsigned NC    = 4;
  localparam int unsigned W     = CW * NC;
  localparam int unsigned NSTEP = NC * NC;

  typedef logic [3:0] step_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  typedef struct packed {
    logic [1:0] i;
    logic [1:0] j;
  } pair_t;

  // Vertical-and-crosswise order: column k=i+j ascending, ascending i within a column.
  function automatic pair_t sched(input step_t s);
    pair_t r;
    unique case (s)
      4'd0:  r = '{i: 2'd0, j: 2'd0};
      4'd1:  r = '{i: 2'd0, j: 2'd1};
      4'd2:  r = '{i: 2'd1, j: 2'd0};
      4'd3:  r = '{i: 2'd0, j: 2'd2};
      4'd4:  r = '{i: 2'd1, j: 2'd1};
      4'd5:  r = '{i: 2'd2, j: 2'd0};
      4'd6:  r = '{i: 2'd0, j: 2'd3};
      4'd7:  r = '{i: 2'd1, j: 2'd2};
      4'd8:  r = '{i: 2'd2, j: 2'd1};
      4'd9:  r = '{i: 2'd3, j: 2'd0};
      4'd10: r = '{i: 2'd1, j: 2'd3};
      4'd11: r = '{i: 2'd2, j: 2'd2};
      4'd12: r = '{i: 2'd3, j: 2'd1};
      4'd13: r = '{i: 2'd2, j: 2'd3};
      4'd14: r = '{i: 2'd3, j: 2'd2};
      default: r = '{i: 2'd3, j: 2'd3};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ve8_mul.sv
// 8x8 unsigned combinational multiplier; the single multiplier shared by all
// sixteen partial-product steps.
module ve8_mul
  import ve_pkg::*;
(
  input  logic [CW-1:0]   x,
  input  logic [CW-1:0]   y,
  output logic [2*CW-1:0] z
);

  assign z = (2*CW)'(x) * (2*CW)'(y);

endmodule

// File: rtl/ve32_seq_ctrl.sv
// Sequential 32x32 multiplier: one 8x8 multiply-accumulate per cycle over sixteen
// byte-chunk partial products, valid/ready on both sides.
module ve32_seq_ctrl
  import ve_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*W-1:0] p,
  output logic          busy
);

  state_e         state_q, state_d;
  step_t          step_q, step_d;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic           load;

  pair_t          cur;
  logic [CW-1:0]  mul_a, mul_b;
  logic [2*CW-1:0] pp;
  logic [2:0]     col;
  logic [5:0]     shamt;
  logic [2*W-1:0] addend;

  assign cur    = sched(step_q);
  assign mul_a  = a_q[CW*cur.i +: CW];
  assign mul_b  = b_q[CW*cur.j +: CW];
  assign col    = 3'(cur.i) + 3'(cur.j);
  assign shamt  = 6'(col) * 6'(CW);
  assign addend = (2*W)'(pp) << shamt;

  ve8_mul u_mul (
    .x (mul_a),
    .y (mul_b),
    .z (pp)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StBusy;
          step_d  = '0;
          acc_d   = '0;
          load    = 1'b1;
        end
      end
      StBusy: begin
        acc_d  = acc_q + addend;
        step_d = step_q + 4'd1;
        if (step_q == 4'(NSTEP - 1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign p         = acc_q;

endmodule

// File: tb/tb_ve32_seq_ctrl.sv
// Directed bench for ve32_seq_ctrl: expected products are queued at acceptance
// and compared when the result is handed off.
module tb_ve32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  ve32_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for acceptance; returns 1ns after the acceptance edge.
  task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(in_ready), 64'd1);
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    sb.push_back({32'd0, aa} * {32'd0, bb});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges until out_valid, starting from 'start' edges already elapsed.
  task automatic wait_done(input string tag, input int start);
    int lat = start;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(tag, 64'(lat), 64'd16);
  endtask

  task automatic consume(input string tag);
    logic [63:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    chk(tag, p, exp);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("idle_no_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] hold_p;
    logic        any_ov;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_p", p, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic product and latency
    issue(32'd5, 32'd7);
    chk("busy_after_accept", 64'(busy), 64'd1);
    wait_done("lat_5x7", 0);
    consume("p_5x7");

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("lat_max", 0);
    consume("p_max");

    issue(32'h0102_0304, 32'h100);
    wait_done("lat_shift", 0);
    consume("p_shift");

    issue(32'd0, 32'h1234_5678);
    wait_done("lat_zero", 0);
    consume("p_zero");

    // Backpressure in DONE
    issue(32'hDEAD_BEEF, 32'h1357_9BDF);
    wait_done("lat_bp", 0);
    hold_p = p;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_p_stable", p, hold_p);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    consume("p_bp");

    // Operand churn during BUSY, out_ready held high early
    issue(32'h89AB_CDEF, 32'h0F0F_0F0F);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("churn_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    wait_done("lat_churn", 3);
    chk("p_churn", p, (sb.size() != 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD);
    @(posedge clk);
    #1;
    chk("churn_consumed", 64'(out_valid), 64'd0);
    chk("churn_back_idle", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    chk("churn_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-operation
    issue(32'h1111_2222, 32'h3333_4444);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_p", p, 64'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n  = 1'b1;
    any_ov = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_ov = any_ov | out_valid;
    end
    chk("mid_rst_no_result", 64'(any_ov), 64'd0);

    issue(32'h0001_0000, 32'h0001_0000);
    wait_done("lat_post_rst", 0);
    consume("p_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
